cla_serial_addsub_ctrl: RTL and testbench

Multi-cycle WIDTH-bit add/subtract engine that time-shares one 4-bit carry-look-ahead slice.
- Sequences the operands through the slice 4 bits per cycle, least-significant nibble first.
- Holds the inter-slice carry in a register.
- Presents the full-width result with carry and signed-overflow flags behind valid/ready handshakes.
- Sits between the ALU issue logic and the writeback stage for area-constrained arithmetic.

---
 rtl/cla_serial_addsub_ctrl_pkg.sv | 19 +
 rtl/cla_serial_addsub_ctrl_cla4.sv | 30 +++
 rtl/cla_serial_addsub_ctrl.sv | 137 +++++++++++++
 tb/tb_cla_serial_addsub_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/cla_serial_addsub_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/subtract controller.
// Holds the FSM state type, the slice width and the slice-index width helper.
// No logic lives here; importers are the controller and its testbench-facing top.
package cla_serial_addsub_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 4;

  // Width of a counter indexing 'slices' slices; never narrower than one bit.
  function automatic int idx_width(input int slices);
    return (slices > 1) ? $clog2(slices) : 1;
  endfunction

endpackage

// File: rtl/cla_serial_addsub_ctrl_cla4.sv
// Purpose: 4-bit carry-look-ahead adder slice, shared by the serial controller.
// Latency: combinational. Backpressure: none (pure function of a, b, cin).
// Ports: a, b (4-bit addends), cin (carry in) -> sum (4-bit), cout (carry out).
module CarryLookAhead4Bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p = a ^ b;
  assign g = a & b;

  // Flattened look-ahead carries, each a function of cin and the p/g terms only.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];

endmodule

// File: rtl/cla_serial_addsub_ctrl.sv
// Purpose: WIDTH-bit add/subtract that runs one shared 4-bit CLA slice LS nibble first.
// Latency: out_valid rises WIDTH/4 cycles after the accepting edge; one op in flight.
// Backpressure: in_ready only in IDLE; result/flags held in DONE until out_ready.
// Ports: clk, rst (sync, active-high); in_valid/in_ready with op_a, op_b, sub;
//        out_valid/out_ready with result, carry_out (sub: 1 = no borrow), overflow.
module cla_serial_addsub_ctrl
  import cla_serial_addsub_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int SLICES = WIDTH / SLICE_W;
  localparam int CW     = idx_width(SLICES);

  if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_width_check
    $error("cla_serial_addsub_ctrl: WIDTH must be a multiple of 4 and >= 4");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;     // effective B: already inverted for subtract
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [3:0] a_nib, b_nib, sum_nib;
  logic       slice_cout;
  logic       last_slice;

  assign last_slice = (cnt_q == CW'(SLICES - 1));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last_slice) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // ---------------- shared slice ----------------
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int s = 0; s < SLICES; s++) begin
      if (cnt_q == CW'(s)) begin
        a_nib = a_q[s*SLICE_W +: SLICE_W];
        b_nib = b_q[s*SLICE_W +: SLICE_W];
      end
    end
  end

  CarryLookAhead4Bit u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_q),
    .sum  (sum_nib),
    .cout (slice_cout)
  );

  // ---------------- datapath next state ----------------
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtract as A + ~B + 1: the +1 enters as the first slice's carry-in.
          a_d     = op_a;
          b_d     = op_b ^ {WIDTH{sub}};
          carry_d = sub;
          cnt_d   = '0;
        end
      end
      RUN: begin
        for (int s = 0; s < SLICES; s++) begin
          if (cnt_q == CW'(s)) res_d[s*SLICE_W +: SLICE_W] = sum_nib;
        end
        carry_d = slice_cout;
        cnt_d   = last_slice ? '0 : cnt_q + CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operands are frozen through DONE, so the flags are stable while out_ready is low.
  assign result    = res_q;
  assign carry_out = carry_q;
  assign overflow  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_q[WIDTH-1] != a_q[WIDTH-1]);

endmodule

// File: tb/tb_cla_serial_addsub_ctrl.sv
module tb_cla_serial_addsub_ctrl;

  localparam int W = 32;
  localparam int LAT = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cla_serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer arithmetic, then read off the wrapped result and flags.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output logic [W-1:0] r, output logic c, output logic v);
    longint sa, sb, ex;
    longint ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    ex = s ? (sa - sb) : (sa + sb);
    v  = (ex > 64'sd2147483647) || (ex < -64'sd2147483648);
    r  = s ? W'(ua - ub) : W'(ua + ub);
    c  = s ? (ua >= ub) : (((ua + ub) >> 32) != 0);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one op, check latency and outputs, optionally stall in DONE for 'hold' cycles.
  // early=1 keeps out_ready high from acceptance onward.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input int hold, input logic early);
    logic [W-1:0] er;
    logic ec, ev;
    int n;
    model(a, b, s, er, ec, ev);
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check_val("in_ready_before_op", {31'd0, in_ready}, 1);
    in_valid  = 1'b1;
    op_a      = a;
    op_b      = b;
    sub       = s;
    out_ready = early;
    tick();
    in_valid = 1'b0;
    op_a     = $urandom;
    op_b     = $urandom;
    sub      = $urandom_range(0, 1);
    n = 0;
    while (!out_valid && n < 40) begin
      check_val("in_ready_busy", {31'd0, in_ready}, 0);
      tick();
      n++;
    end
    check_val("latency", n, LAT);
    check_val("result", result, er);
    check_val("carry_out", {31'd0, carry_out}, {31'd0, ec});
    check_val("overflow", {31'd0, overflow}, {31'd0, ev});
    if (!early) begin
      for (int h = 0; h < hold; h++) begin
        in_valid = 1'b1;
        tick();
        check_val("hold_valid", {31'd0, out_valid}, 1);
        check_val("hold_in_ready", {31'd0, in_ready}, 0);
        check_val("hold_result", result, er);
        check_val("hold_flags", {30'd0, carry_out, overflow}, {30'd0, ec, ev});
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    tick();
    out_ready = 1'b0;
    check_val("drain_out_valid", {31'd0, out_valid}, 0);
    check_val("drain_in_ready", {31'd0, in_ready}, 1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    sub       = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();
    check_val("rst_in_ready", {31'd0, in_ready}, 1);
    check_val("rst_out_valid", {31'd0, out_valid}, 0);
    check_val("rst_result", result, 0);
    check_val("rst_flags", {30'd0, carry_out, overflow}, 0);
    rst = 1'b0;
    tick();

    run_op(32'h0000000F, 32'h00000001, 1'b0, 0, 1'b0);
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 0, 1'b0);
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 0, 1'b0);
    run_op(32'h00000005, 32'h00000007, 1'b1, 0, 1'b0);
    run_op(32'h80000000, 32'h00000001, 1'b1, 0, 1'b0);
    run_op(32'h00000000, 32'h00000000, 1'b1, 0, 1'b0);
    run_op(32'h12345678, 32'h9ABCDEF0, 1'b0, 5, 1'b0);
    run_op(32'hDEADBEEF, 32'h01234567, 1'b1, 0, 1'b0);
    run_op(32'h00000001, 32'h00000001, 1'b0, 0, 1'b1);

    // Reset during the third RUN cycle abandons the op.
    in_valid = 1'b1;
    op_a     = 32'hFFFFFFFF;
    op_b     = 32'h00000001;
    sub      = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("midrun_rst_in_ready", {31'd0, in_ready}, 1);
    check_val("midrun_rst_out_valid", {31'd0, out_valid}, 0);
    check_val("midrun_rst_result", result, 0);
    check_val("midrun_rst_flags", {30'd0, carry_out, overflow}, 0);
    run_op(32'h12345678, 32'h11111111, 1'b0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if (i % 8 == 1) rb = ra;
      if (i % 8 == 2) ra = {1'b1, 31'd0};
      run_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
